// File: rtl/accel_control_slave.sv
// Avalon-MM control/status slave for the audio-sum accelerator: job descriptor, Go/DONE/Master_Done handshake, IRQ.
// Writes land on the strobe edge; reads stall one cycle on WAITREQUEST; GO rises one cycle after START.
module accel_control_slave #(
  parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
  parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 3
) (
  input  logic                                     CSI_CLOCK_CLK,
  input  logic                                     CSI_CLOCK_RESET,
  input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] AVS_AVALONSLAVE_ADDRESS,
  input  logic                                     AVS_AVALONSLAVE_READ,
  input  logic                                     AVS_AVALONSLAVE_WRITE,
  input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_WRITEDATA,
  output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_READDATA,
  output logic                                     AVS_AVALONSLAVE_WAITREQUEST,
  output logic                                     INS_IRQ_IRQ,
  output logic                                     GO,
  input  logic                                     DONE,
  output logic                                     MASTER_DONE,
  output logic [31:0]                              LEFT_BASE,
  output logic [31:0]                              RIGHT_BASE,
  output logic [31:0]                              DEST_BASE,
  output logic [18:0]                              SIZE,
  output logic [10:0]                              NUMBER
);
  localparam int DW = AVS_AVALONSLAVE_DATA_WIDTH;
  localparam int AW = AVS_AVALONSLAVE_ADDRESS_WIDTH;

  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_STATUS = AW'(1);
  localparam logic [AW-1:0] A_LEFT   = AW'(2);
  localparam logic [AW-1:0] A_RIGHT  = AW'(3);
  localparam logic [AW-1:0] A_DEST   = AW'(4);
  localparam logic [AW-1:0] A_SIZE   = AW'(5);
  localparam logic [AW-1:0] A_NUMBER = AW'(6);
  localparam logic [AW-1:0] A_CYCLES = AW'(7);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_ACK} state_t;

  state_t        state;
  logic          irq_en;
  logic          done_sticky;
  logic          err;
  logic [31:0]   cycles;
  logic          busy;
  logic          start_req;
  logic          cfg_wr;
  logic          rd_ack;
  logic [DW-1:0] rd_mux;

  assign busy      = (state != S_IDLE);
  assign start_req = AVS_AVALONSLAVE_WRITE && (AVS_AVALONSLAVE_ADDRESS == A_CTRL) &&
                     AVS_AVALONSLAVE_WRITEDATA[0];
  assign cfg_wr    = AVS_AVALONSLAVE_WRITE && (AVS_AVALONSLAVE_ADDRESS >= A_LEFT) &&
                     (AVS_AVALONSLAVE_ADDRESS <= A_NUMBER);

  assign INS_IRQ_IRQ                 = irq_en & done_sticky;
  assign AVS_AVALONSLAVE_WAITREQUEST = AVS_AVALONSLAVE_READ && !rd_ack;

  // Descriptor registers are frozen while a job is in flight.
  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      irq_en     <= 1'b0;
      LEFT_BASE  <= '0;
      RIGHT_BASE <= '0;
      DEST_BASE  <= '0;
      SIZE       <= '0;
      NUMBER     <= '0;
    end else if (AVS_AVALONSLAVE_WRITE) begin
      if (AVS_AVALONSLAVE_ADDRESS == A_CTRL) irq_en <= AVS_AVALONSLAVE_WRITEDATA[2];
      if (cfg_wr && !busy) begin
        case (AVS_AVALONSLAVE_ADDRESS)
          A_LEFT:   LEFT_BASE  <= AVS_AVALONSLAVE_WRITEDATA[31:0];
          A_RIGHT:  RIGHT_BASE <= AVS_AVALONSLAVE_WRITEDATA[31:0];
          A_DEST:   DEST_BASE  <= AVS_AVALONSLAVE_WRITEDATA[31:0];
          A_SIZE:   SIZE       <= AVS_AVALONSLAVE_WRITEDATA[18:0];
          A_NUMBER: NUMBER     <= AVS_AVALONSLAVE_WRITEDATA[10:0];
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      state       <= S_IDLE;
      GO          <= 1'b0;
      MASTER_DONE <= 1'b0;
      done_sticky <= 1'b0;
      err         <= 1'b0;
      cycles      <= '0;
    end else begin
      if (AVS_AVALONSLAVE_WRITE && (AVS_AVALONSLAVE_ADDRESS == A_STATUS)) begin
        if (AVS_AVALONSLAVE_WRITEDATA[1]) done_sticky <= 1'b0;
        if (AVS_AVALONSLAVE_WRITEDATA[2]) err         <= 1'b0;
      end
      if (busy && (start_req || cfg_wr)) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_req) begin
            state       <= S_LAUNCH;
            GO          <= 1'b1;
            cycles      <= '0;
            done_sticky <= 1'b0;
          end
        end
        // DONE may still be high from the previous job; wait for it to drop first.
        S_LAUNCH: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          if (!DONE) state <= S_RUN;
        end
        S_RUN: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          if (DONE) begin
            state       <= S_ACK;
            GO          <= 1'b0;
            MASTER_DONE <= 1'b1;
          end
        end
        S_ACK: begin
          MASTER_DONE <= 1'b0;
          done_sticky <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (AVS_AVALONSLAVE_ADDRESS)
      A_CTRL:   rd_mux = DW'({irq_en, 2'b00});
      A_STATUS: rd_mux = DW'({err, done_sticky, busy});
      A_LEFT:   rd_mux = DW'(LEFT_BASE);
      A_RIGHT:  rd_mux = DW'(RIGHT_BASE);
      A_DEST:   rd_mux = DW'(DEST_BASE);
      A_SIZE:   rd_mux = DW'(SIZE);
      A_NUMBER: rd_mux = DW'(NUMBER);
      A_CYCLES: rd_mux = DW'(cycles);
      default:  rd_mux = '0;
    endcase
  end

  // rd_ack marks the data cycle, so back-to-back reads each take one wait state.
  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      rd_ack                   <= 1'b0;
      AVS_AVALONSLAVE_READDATA <= '0;
    end else begin
      rd_ack <= AVS_AVALONSLAVE_READ && !rd_ack;
      if (AVS_AVALONSLAVE_READ && !rd_ack) AVS_AVALONSLAVE_READDATA <= rd_mux;
    end
  end
endmodule

// File: tb/tb_accel_control_slave.sv
// Bench for accel_control_slave: job-level reference model, per-cycle output compare, directed and random bus traffic.
module tb_accel_control_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = 3'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        waitreq, irq, go, mdone;
  logic        done = 1'b0;
  logic [31:0] left, right, dest;
  logic [18:0] size;
  logic [10:0] number;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accel_control_slave dut (
    .CSI_CLOCK_CLK(clk), .CSI_CLOCK_RESET(rst),
    .AVS_AVALONSLAVE_ADDRESS(addr), .AVS_AVALONSLAVE_READ(rd), .AVS_AVALONSLAVE_WRITE(wr),
    .AVS_AVALONSLAVE_WRITEDATA(wdata), .AVS_AVALONSLAVE_READDATA(rdata),
    .AVS_AVALONSLAVE_WAITREQUEST(waitreq), .INS_IRQ_IRQ(irq), .GO(go), .DONE(done),
    .MASTER_DONE(mdone), .LEFT_BASE(left), .RIGHT_BASE(right), .DEST_BASE(dest),
    .SIZE(size), .NUMBER(number)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model. Job phase: 0 idle, 1 waiting for stale DONE to drop, 2 waiting for DONE, 3 acknowledging.
  bit [31:0] m_left, m_right, m_dest, m_cycles;
  bit [18:0] m_size;
  bit [10:0] m_num;
  bit        m_irq_en, m_sticky, m_err;
  int        m_phase;

  always @(posedge clk or posedge rst) begin
    bit busy, start;
    if (rst) begin
      m_left = 0; m_right = 0; m_dest = 0; m_cycles = 0; m_size = 0; m_num = 0;
      m_irq_en = 0; m_sticky = 0; m_err = 0; m_phase = 0;
    end else begin
      busy  = (m_phase != 0);
      start = 1'b0;
      if (wr) begin
        case (addr)
          3'd0: begin
            m_irq_en = wdata[2];
            if (wdata[0]) begin
              if (busy) m_err = 1'b1; else start = 1'b1;
            end
          end
          3'd1: begin
            if (wdata[1]) m_sticky = 1'b0;
            if (wdata[2]) m_err = 1'b0;
          end
          3'd7: ;
          default: begin
            if (busy) m_err = 1'b1;
            else if (addr == 3'd2) m_left = wdata;
            else if (addr == 3'd3) m_right = wdata;
            else if (addr == 3'd4) m_dest = wdata;
            else if (addr == 3'd5) m_size = wdata[18:0];
            else m_num = wdata[10:0];
          end
        endcase
      end
      if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_cycles = 0; m_sticky = 1'b0; end
      end else if (m_phase == 3) begin
        m_sticky = 1'b1; m_phase = 0;
      end else begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (m_phase == 1 && !done) m_phase = 2;
        else if (m_phase == 2 && done) m_phase = 3;
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {29'd0, m_irq_en, 2'b00};
      3'd1:    return {29'd0, m_err, m_sticky, (m_phase != 0)};
      3'd2:    return m_left;
      3'd3:    return m_right;
      3'd4:    return m_dest;
      3'd5:    return {13'd0, m_size};
      3'd6:    return {21'd0, m_num};
      default: return m_cycles;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst)
      chk("outputs", {go, mdone, irq, left, right, dest, size, number},
          {(m_phase == 1 || m_phase == 2), (m_phase == 3), (m_irq_en & m_sticky),
           m_left, m_right, m_dest, m_size, m_num});
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    logic [31:0] e;
    addr = a; rd = 1'b1;
    #1;
    chk("rd_wait_first", waitreq, 1'b1);
    e = m_read(a);
    @(posedge clk); #1;
    chk("rd_wait_second", waitreq, 1'b0);
    chk("rd_data", rdata, e);
    d = rdata;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_go", go, 1'b0);
    chk("reset_mdone", mdone, 1'b0);
    chk("reset_irq", irq, 1'b0);
    chk("reset_waitreq", waitreq, 1'b0);
    chk("reset_rdata", rdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(i[2:0], d);
      chk("reset_read", d, 32'd0);
    end

    bus_wr(3'd2, 32'h1000); bus_wr(3'd3, 32'h2000); bus_wr(3'd4, 32'h3000);
    bus_wr(3'd5, 32'hFFFF_FFFF); bus_wr(3'd6, 32'd5);
    bus_rd(3'd2, d); chk("left_rb", d, 32'h1000);
    bus_rd(3'd3, d); chk("right_rb", d, 32'h2000);
    bus_rd(3'd4, d); chk("dest_rb", d, 32'h3000);
    bus_rd(3'd5, d); chk("size_rb", d, 32'h7FFFF);
    bus_rd(3'd6, d); chk("number_rb", d, 32'd5);
    chk("left_port", left, 32'h1000);
    chk("size_port", size, 19'h7FFFF);
    chk("number_port", number, 11'd5);

    // Job 1: IRQ_EN + START, DONE after 100 cycles.
    bus_wr(3'd0, 32'h5);
    chk("go_after_start", go, 1'b1);
    repeat (100) @(posedge clk);
    #1 chk("go_before_done", go, 1'b1);
    done = 1'b1;
    @(posedge clk); #1;
    chk("go_after_done", go, 1'b0);
    chk("mdone_pulse", mdone, 1'b1);
    @(posedge clk); #1;
    chk("mdone_single", mdone, 1'b0);
    chk("irq_set", irq, 1'b1);
    bus_rd(3'd1, d); chk("status_done", d, 32'h2);
    bus_rd(3'd7, d); chk("cycles_job1", d, 32'd101);
    bus_wr(3'd1, 32'h2);
    chk("irq_cleared", irq, 1'b0);

    // Job 2 starts with DONE still high; also exercise ERR while busy.
    bus_wr(3'd0, 32'h5);
    repeat (20) @(posedge clk);
    #1 chk("stale_done_go", go, 1'b1);
    chk("stale_done_no_ack", mdone, 1'b0);
    bus_rd(3'd1, d); chk("status_busy", d, 32'h1);
    bus_wr(3'd2, 32'hABCD);
    bus_wr(3'd0, 32'h5);
    chk("left_frozen", left, 32'h1000);
    bus_rd(3'd1, d); chk("status_err", d, 32'h5);
    bus_wr(3'd1, 32'h4);
    bus_rd(3'd1, d); chk("status_err_clr", d, 32'h1);
    done = 1'b0;
    repeat (5) @(posedge clk);
    #1 done = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("irq_job2", irq, 1'b1);
    bus_rd(3'd1, d); chk("status_job2", d, 32'h2);

    // Reset in the middle of a job.
    bus_wr(3'd1, 32'h2);
    done = 1'b0;
    bus_wr(3'd0, 32'h5);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("rst_go", go, 1'b0);
    chk("rst_left", left, 32'd0);
    chk("rst_number", number, 11'd0);
    chk("rst_irq", irq, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    bus_rd(3'd1, d); chk("rst_status", d, 32'd0);
    bus_rd(3'd0, d); chk("rst_ctrl", d, 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) done = ~done;
      case ($urandom_range(0, 5))
        0, 1:    begin @(posedge clk); #1; end
        2, 3, 4: bus_wr(3'($urandom_range(0, 7)), $urandom);
        default: bus_rd(3'($urandom_range(0, 7)), d);
      endcase
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
